scr1_tcm_sp_arb: RTL

Arbiter and sequencer that shares one single-port 32-bit TCM SRAM between the core instruction interface (imem) and the core data interface (dmem). It grants at most one requester per cycle and drives the SRAM port. It returns read data and responses one cycle after the grant. It also generates byte enables and replicated write data, and rejects out-of-range or misaligned accesses. It sits between the core memory router and the SRAM macro, in the place of a dual-port TCM where area rules out a second port.

---
 rtl/scr1_tcm_sp_arb_if.sv | 66 ++++++
 rtl/scr1_tcm_sp_arb.sv | 130 +++++++++++++
 2 files changed

// File: rtl/scr1_tcm_sp_arb_if.sv
// Memory-access types and the imem/dmem/SRAM bundle for the single-port TCM arbiter.
// The slave modport is the arbiter's view; the master modport is the core and SRAM side.
package scr1_tcm_sp_arb_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

interface scr1_tcm_sp_arb_if #(
    parameter int unsigned SCR1_TCM_SIZE = 32'h00010000
) ();
    localparam int unsigned AW = $clog2(SCR1_TCM_SIZE) - 2;

    logic                                      imem_req;
    logic                                      imem_req_ack;
    logic [31:0]                               imem_addr;
    logic [31:0]                               imem_rdata;
    scr1_tcm_sp_arb_pkg::type_scr1_mem_resp_e  imem_resp;

    logic                                      dmem_req;
    logic                                      dmem_req_ack;
    scr1_tcm_sp_arb_pkg::type_scr1_mem_cmd_e   dmem_cmd;
    scr1_tcm_sp_arb_pkg::type_scr1_mem_width_e dmem_width;
    logic [31:0]                               dmem_addr;
    logic [31:0]                               dmem_wdata;
    logic [31:0]                               dmem_rdata;
    scr1_tcm_sp_arb_pkg::type_scr1_mem_resp_e  dmem_resp;

    logic                                      mem_ren;
    logic                                      mem_wen;
    logic [3:0]                                mem_be;
    logic [AW-1:0]                             mem_addr;
    logic [31:0]                               mem_wdata;
    logic [31:0]                               mem_rdata;

    modport slave (
        input  imem_req, imem_addr,
        output imem_req_ack, imem_rdata, imem_resp,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp,
        output mem_ren, mem_wen, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output imem_req, imem_addr,
        input  imem_req_ack, imem_rdata, imem_resp,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp,
        input  mem_ren, mem_wen, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/scr1_tcm_sp_arb.sv
// Shares one single-port TCM SRAM between imem and dmem: dmem has priority,
// imem is forced through after STARVE_LIMIT consecutive losses; responses follow grants by one cycle.
//
// resp_src  | meaning
// SRC_NONE  | no access granted last cycle, both responses NOTRDY
// SRC_IMEM  | imem granted last cycle, imem gets RDY_OK/RDY_ER
// SRC_DMEM  | dmem granted last cycle, dmem gets RDY_OK/RDY_ER
module scr1_tcm_sp_arb
    import scr1_tcm_sp_arb_pkg::*;
#(
    parameter int unsigned SCR1_TCM_SIZE = 32'h00010000,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    scr1_tcm_sp_arb_if.slave  bus
);
    localparam int unsigned BW = $clog2(SCR1_TCM_SIZE);
    localparam int unsigned AW = BW - 2;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_IMEM = 2'b01,
        SRC_DMEM = 2'b10
    } resp_src_e;

    resp_src_e   r_resp_src, w_resp_src_nxt;
    logic        r_resp_err, w_resp_err_nxt;
    logic [1:0]  r_shift, w_shift_nxt;
    logic [3:0]  r_starve_cnt, w_starve_cnt_nxt;

    logic        w_imem_oor, w_dmem_oor, w_dmem_mis, w_dmem_err;
    logic        w_starved, w_gnt_imem, w_gnt_dmem, w_dmem_wr;
    logic        w_mem_wen;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^bus.imem_addr[1:0];

    assign w_imem_oor = |bus.imem_addr[31:BW];
    assign w_dmem_oor = |bus.dmem_addr[31:BW];

    always_comb begin
        w_dmem_mis = 1'b0;
        case (bus.dmem_width)
            SCR1_MEM_WIDTH_BYTE:  w_dmem_mis = 1'b0;
            SCR1_MEM_WIDTH_HWORD: w_dmem_mis = bus.dmem_addr[0];
            SCR1_MEM_WIDTH_WORD:  w_dmem_mis = |bus.dmem_addr[1:0];
            default:              w_dmem_mis = 1'b1;
        endcase
    end
    assign w_dmem_err = w_dmem_oor | w_dmem_mis;

    assign w_starved  = (r_starve_cnt == 4'(STARVE_LIMIT));
    assign w_gnt_imem = bus.imem_req & (~bus.dmem_req | w_starved);
    assign w_gnt_dmem = bus.dmem_req & ~w_gnt_imem;
    assign w_dmem_wr  = (bus.dmem_cmd == SCR1_MEM_CMD_WR);

    assign bus.imem_req_ack = w_gnt_imem;
    assign bus.dmem_req_ack = w_gnt_dmem;

    // Erroneous grants still win arbitration but never touch the SRAM.
    assign w_mem_wen    = w_gnt_dmem & w_dmem_wr & ~w_dmem_err;
    assign bus.mem_wen  = w_mem_wen;
    assign bus.mem_ren  = (w_gnt_imem & ~w_imem_oor) | (w_gnt_dmem & ~w_dmem_wr & ~w_dmem_err);
    assign bus.mem_addr = w_gnt_imem ? bus.imem_addr[BW-1:2] : bus.dmem_addr[BW-1:2];

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.dmem_wdata;
        case (bus.dmem_width)
            SCR1_MEM_WIDTH_BYTE: begin
                w_be    = 4'b0001 << bus.dmem_addr[1:0];
                w_wdata = {4{bus.dmem_wdata[7:0]}};
            end
            SCR1_MEM_WIDTH_HWORD: begin
                w_be    = 4'b0011 << {bus.dmem_addr[1], 1'b0};
                w_wdata = {2{bus.dmem_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.dmem_wdata;
            end
        endcase
    end
    assign bus.mem_be    = w_mem_wen ? w_be : 4'b0000;
    assign bus.mem_wdata = w_wdata;

    always_comb begin
        w_resp_src_nxt   = SRC_NONE;
        w_resp_err_nxt   = 1'b0;
        w_shift_nxt      = 2'b00;
        w_starve_cnt_nxt = r_starve_cnt;
        if (w_gnt_imem) begin
            w_resp_src_nxt = SRC_IMEM;
            w_resp_err_nxt = w_imem_oor;
        end else if (w_gnt_dmem) begin
            w_resp_src_nxt = SRC_DMEM;
            w_resp_err_nxt = w_dmem_err;
            w_shift_nxt    = bus.dmem_addr[1:0];
        end
        if (~bus.imem_req | w_gnt_imem) begin
            w_starve_cnt_nxt = 4'd0;
        end else if (w_gnt_dmem & ~w_starved) begin
            w_starve_cnt_nxt = r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_src   <= SRC_NONE;
            r_resp_err   <= 1'b0;
            r_shift      <= 2'b00;
            r_starve_cnt <= 4'd0;
        end else begin
            r_resp_src   <= w_resp_src_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_shift      <= w_shift_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

    assign bus.imem_resp  = (r_resp_src != SRC_IMEM) ? SCR1_MEM_RESP_NOTRDY :
                            (r_resp_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK);
    assign bus.dmem_resp  = (r_resp_src != SRC_DMEM) ? SCR1_MEM_RESP_NOTRDY :
                            (r_resp_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK);
    assign bus.imem_rdata = bus.mem_rdata;
    assign bus.dmem_rdata = bus.mem_rdata >> {r_shift, 3'b000};
endmodule
